// File: rtl/rr_dispatch_buffer.sv
// rr_dispatch_buffer
//   Decoupling queue in front of the register-rename stage. Decode pushes
//   groups of INSTR_COUNT logical destination registers over valid/ready.
//   Rename sees the oldest buffered group under a valid/stall protocol. A
//   recovery request flushes every buffered (wrong-path) group. While rename
//   is recovering, the output is withheld but correct-path groups are still
//   accepted.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   in_valid     decode presents a group
//   in_l_dst     incoming group, slot i at [i*LREG_W +: LREG_W]
//   in_ready     buffer accepts the group this cycle
//   l_dst        head group to rename (same slot packing as in_l_dst)
//   l_dst_valid  head group valid
//   inst_en      identical copy of l_dst_valid
//   stall        rename cannot take the head this cycle
//   rec_en       recovery request: flush buffer
//   rec_busy     rename is in recovery: mask output, keep accepting input
//   count        occupied entries
module rr_dispatch_buffer #(
  parameter int INSTR_COUNT = 2,
  parameter int L_REGISTERS = 32,
  parameter int DEPTH       = 4,
  localparam int LREG_W     = $clog2(L_REGISTERS),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [INSTR_COUNT*LREG_W-1:0] in_l_dst,
  output logic                          in_ready,
  output logic [INSTR_COUNT*LREG_W-1:0] l_dst,
  output logic                          l_dst_valid,
  output logic                          inst_en,
  input  logic                          stall,
  input  logic                          rec_en,
  input  logic                          rec_busy,
  output logic [CNT_W-1:0]              count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int GRP_W = INSTR_COUNT * LREG_W;

  logic [GRP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;

  // in_ready deliberately ignores a same-cycle pop, so a full buffer refuses
  // input even while draining. This keeps a stall-to-ready path out of decode.
  assign in_ready    = (count < CNT_W'(DEPTH)) && !rec_en;
  assign l_dst_valid = (count != '0) && !rec_en && !rec_busy;
  assign inst_en     = l_dst_valid;
  assign push        = in_valid && in_ready;
  assign pop         = l_dst_valid && !stall;

  // Head is read straight from registered storage. Nothing from the inputs
  // reaches l_dst within the same cycle.
  assign l_dst = mem[head];

  // NOTE: storage has no reset. Only entries between head and tail are ever
  // presented, and each of those was written by a push first.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_l_dst;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch reads the pre-edge values of head/tail/count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rec_en) begin
      // Flush wins over everything. push and pop are already gated off by
      // rec_en, so no half-applied transfer can leak through.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && count == CNT_W'(DEPTH)))
        else $fatal(1, "rr_dispatch_buffer: push while full");
      assert (!(pop && count == '0))
        else $fatal(1, "rr_dispatch_buffer: pop while empty");
      assert (!(in_valid && $isunknown(in_l_dst)))
        else $fatal(1, "rr_dispatch_buffer: unknown in_l_dst with in_valid");
    end
  end
`endif

endmodule

// File: tb/tb_rr_dispatch_buffer.sv
module tb_rr_dispatch_buffer;

  localparam int INSTR_COUNT = 2;
  localparam int L_REGISTERS = 32;
  localparam int DEPTH       = 4;
  localparam int LREG_W      = $clog2(L_REGISTERS);
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int GRP_W       = INSTR_COUNT * LREG_W;

  typedef logic [GRP_W-1:0] grp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  grp_t             in_l_dst;
  logic             in_ready;
  grp_t             l_dst;
  logic             l_dst_valid;
  logic             inst_en;
  logic             stall;
  logic             rec_en;
  logic             rec_busy;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain FIFO of groups. Occupancy is simply its size.
  grp_t model_q[$];

  rr_dispatch_buffer #(
    .INSTR_COUNT(INSTR_COUNT),
    .L_REGISTERS(L_REGISTERS),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_l_dst   (in_l_dst),
    .in_ready   (in_ready),
    .l_dst      (l_dst),
    .l_dst_valid(l_dst_valid),
    .inst_en    (inst_en),
    .stall      (stall),
    .rec_en     (rec_en),
    .rec_busy   (rec_busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic grp_t grp(input int a, input int b);
    grp_t g;
    g[LREG_W-1:0]       = a[LREG_W-1:0];
    g[GRP_W-1:LREG_W]   = b[LREG_W-1:0];
    return g;
  endfunction

  function automatic logic m_valid();
    return (model_q.size() != 0) && !rec_en && !rec_busy;
  endfunction

  function automatic logic m_ready();
    return (model_q.size() < DEPTH) && !rec_en;
  endfunction

  function automatic logic [CNT_W-1:0] m_count();
    return CNT_W'(model_q.size());
  endfunction

  task automatic set_in(input logic iv, input grp_t d, input logic st,
                        input logic re, input logic rb);
    in_valid = iv;
    in_l_dst = d;
    stall    = st;
    rec_en   = re;
    rec_busy = rb;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic do_push, do_pop, do_flush;
    grp_t d;
    do_flush = !rst_n || rec_en;
    do_pop   = m_valid() && !stall;
    do_push  = in_valid && m_ready();
    d        = in_l_dst;
    @(posedge clk);
    if (do_flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (count !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_cmp++;
    if (l_dst_valid !== 1'b0 || inst_en !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b/%b expected 0/0", l_dst_valid, inst_en);
    end
  endtask

  task automatic test_single();
    set_in(1'b1, grp(5, 7), 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (l_dst_valid !== 1'b0) begin
      n_err++; $display("FAIL single_no_bypass: got %b expected 0", l_dst_valid);
    end
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (l_dst_valid !== 1'b1 || l_dst !== grp(5, 7)) begin
      n_err++; $display("FAIL single_out: got v=%b d=%0h expected v=1 d=%0h",
                        l_dst_valid, l_dst, grp(5, 7));
    end
    tick();
    n_cmp++;
    if (count !== '0 || l_dst_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got cnt=%0d v=%b expected cnt=0 v=0",
                        count, l_dst_valid);
    end
  endtask

  task automatic test_stall_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, grp(2*i+1, 2*i+2), 1'b1, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (l_dst_valid !== 1'b1 || l_dst !== grp(1, 2)) begin
        n_err++; $display("FAIL stall_hold_%0d: got v=%b d=%0h expected v=1 d=%0h",
                          i, l_dst_valid, l_dst, grp(1, 2));
      end
    end
    #1;
    n_cmp++;
    if (count !== CNT_W'(4) || in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_full: got cnt=%0d rdy=%b expected cnt=4 rdy=0",
                        count, in_ready);
    end
    // Full and popping: the offered group {15,15} must still be refused.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, grp(15, 15), 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (l_dst_valid !== 1'b1 || l_dst !== grp(2*i+1, 2*i+2)) begin
        n_err++; $display("FAIL drain_order_%0d: got v=%b d=%0h expected v=1 d=%0h",
                          i, l_dst_valid, l_dst, grp(2*i+1, 2*i+2));
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (i == 0) in_valid = 1'b1;
      if (i == 0) in_l_dst = grp(15, 15);
      tick();
    end
    n_cmp++;
    if (count !== '0) begin
      n_err++; $display("FAIL drain_empty: got cnt=%0d expected 0 (full push not refused?)", count);
    end
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, grp(0, 31), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 12; i++) begin
      set_in(1'b1, grp(i, 31 - i), 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (count !== CNT_W'(1) || in_ready !== 1'b1 || l_dst_valid !== 1'b1 ||
          l_dst !== grp(i - 1, 32 - i)) begin
        n_err++; $display("FAIL b2b_%0d: got cnt=%0d rdy=%b v=%b d=%0h expected cnt=1 rdy=1 v=1 d=%0h",
                          i, count, in_ready, l_dst_valid, l_dst, grp(i - 1, 32 - i));
      end
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush_and_busy();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, grp(20 + i, i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, grp(30, 30), 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || l_dst_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_gate: got rdy=%b v=%b expected 0/0", in_ready, l_dst_valid);
    end
    tick();
    n_cmp++;
    if (count !== '0) begin
      n_err++; $display("FAIL flush_count: got %0d expected 0", count);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0, grp(9, 10), 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (l_dst_valid !== 1'b0 || count !== CNT_W'(1)) begin
        n_err++; $display("FAIL busy_%0d: got v=%b cnt=%0d expected v=0 cnt=1",
                          i, l_dst_valid, count);
      end
    end
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (l_dst_valid !== 1'b1 || l_dst !== grp(9, 10)) begin
      n_err++; $display("FAIL busy_resume: got v=%b d=%0h expected v=1 d=%0h",
                        l_dst_valid, l_dst, grp(9, 10));
    end
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, grp(i, i + 3), 1'b1, 1'b0, 1'b0);
      tick();
    end
    n_cmp++;
    if (count !== CNT_W'(3)) begin
      n_err++; $display("FAIL mid_pre: got cnt=%0d expected 3", count);
    end
    rst_n = 1'b0;
    set_in(1'b1, grp(1, 1), 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (count !== '0 || l_dst_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got cnt=%0d v=%b rdy=%b expected 0/0/1",
                        count, l_dst_valid, in_ready);
    end
    rst_n = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, grp_t'($urandom()),
             $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      n_cmp++;
      if (count !== m_count() || in_ready !== m_ready() ||
          l_dst_valid !== m_valid() || inst_en !== m_valid() ||
          (m_valid() && l_dst !== model_q[0])) begin
        n_err++;
        $display("FAIL rand_%0d: got cnt=%0d rdy=%b v=%b en=%b d=%0h expected cnt=%0d rdy=%b v=%b d=%0h",
                 i, count, in_ready, l_dst_valid, inst_en, l_dst, m_count(), m_ready(),
                 m_valid(), (model_q.size() != 0) ? model_q[0] : grp_t'(0));
      end
      tick();
    end
    rst_n = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_single();
    test_stall_fill();
    test_back_to_back();
    test_flush_and_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_dispatch_buffer.md
Name: rr_dispatch_buffer

Overview:
- Decoupling queue directly upstream of the register-rename stage.
- Accepts INSTR_COUNT-wide groups of logical destination registers from decode over a valid/ready handshake and buffers up to DEPTH groups.
- Presents the oldest group to rename under its valid/stall protocol.
- Flushes all buffered (wrong-path) groups on recovery and withholds output while rename is recovering.

Parameters:
INSTR_COUNT, 2, instructions per group (rename width)
L_REGISTERS, 32, number of logical registers; LREG_W = $clog2(L_REGISTERS)
DEPTH, 4, buffered groups; power of two, >= 2; CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decode presents a group
in_l_dst  in  INSTR_COUNT x LREG_W  logical destinations of the incoming group
in_ready  out  1  buffer accepts the group this cycle
l_dst  out  INSTR_COUNT x LREG_W  head group to rename
l_dst_valid  out  1  head group valid
inst_en  out  1  identical copy of l_dst_valid
stall  in  1  rename cannot accept the head this cycle
rec_en  in  1  recovery request: flush buffer
rec_busy  in  1  rename is in recovery state
count  out  CNT_W  occupied entries

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active-low, sampled on the rising edge.
- Reset values: head/tail pointers = 0, count = 0, so in_ready = 1 and l_dst_valid = inst_en = 0. Storage contents are not reset. l_dst is don't-care while invalid and must not be X while valid.
- Storage: DEPTH-entry circular array, head and tail pointers $clog2(DEPTH) bits wide, wrapping naturally from DEPTH-1 to 0.
- Output: l_dst = mem[head], read combinationally from registered storage (no input-to-output combinational path).
- Valid: l_dst_valid = (count != 0) && !rec_en && !rec_busy. inst_en is the same signal.
- Push: in_valid && in_ready. in_ready = (count < DEPTH) && !rec_en. in_ready does not depend on a same-cycle pop, so a full buffer refuses input even when popping.
- Pop: l_dst_valid && !stall.
- Latency: a group pushed in cycle N is visible at l_dst, with l_dst_valid high, in cycle N+1 at the earliest. There is no bypass.
- Stability: while l_dst_valid && stall && !rec_en, l_dst and l_dst_valid remain unchanged the next cycle. Pushes must never alter mem[head] while the buffer is non-empty.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Empty with push: count becomes 1 and the output is valid the next cycle (subject to rec_busy).
- Flush on rec_en (edge on which rec_en=1):
  - head = tail = 0, count = 0.
  - Any push that cycle is dropped (in_ready = 0).
  - No pop occurs (l_dst_valid = 0).
  - rec_en overrides all other activity.
- rec_busy = 1:
  - Output is masked (l_dst_valid = 0, no pops).
  - Pushes are still accepted (correct-path groups), up to DEPTH.
  - Output resumes the cycle after rec_busy falls.
- Reset mid-operation: rst_n low forces the reset state on the next edge regardless of in_valid, stall or rec_en.
- Counter: count is CNT_W bits and must never exceed DEPTH or underflow.
- Simulation-only checks:
  - Fatal if a push occurs while count == DEPTH.
  - Fatal if a pop occurs while count == 0.
  - Fatal if in_l_dst contains X while in_valid is high.

Test Plan:
- Reset, then push group {5,7} at cycle 1 with stall=0 -> cycle 2: l_dst_valid=1, l_dst={5,7}; cycle 3: count=0, l_dst_valid=0.
- Hold stall=1 and push 4 groups {1,2},{3,4},{5,6},{7,8} -> count=4, in_ready=0, l_dst stays {1,2} every cycle. Release stall -> groups emerge in order, one per cycle.
- Push and pop every cycle for 12 cycles with DEPTH=4 -> count stays 1, pointers wrap 3 times, data order preserved, in_ready stays 1.
- Full buffer; assert rec_en for 1 cycle with in_valid=1 -> next cycle count=0, l_dst_valid=0, the offered group is dropped.
- rec_en then rec_busy=1 for 3 cycles while pushing {9,10} -> l_dst_valid=0 throughout, count=1. Cycle after rec_busy falls: l_dst_valid=1, l_dst={9,10}.
- Assert rst_n=0 with count=3 and stall=1 -> next edge count=0, l_dst_valid=0, in_ready=1.
